// File: rtl/regfile_ctrl_fsm.sv
// regfile_ctrl_fsm: instruction register plus multi-cycle control sequencer
// for an 8x16 register file and its ALU datapath.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in[15:0]          instruction word, captured into IR by load while idle
//   load, s           load IR / start execution; both accepted only while w=1
//   w                 1 = idle in WAIT, ready for load/s
//   readnum, writenum register-file read/write indices
//   write, vsel       register-file write enable / write-data select (1=sximm8)
//   loada..loads      datapath A/B/C/status register enables
//   asel, bsel        ALU operand selects (A forced to 0 / B from sximm5)
//   aluop, shift      ALU operation and B-operand shifter control
//   sximm8, sximm5    sign-extended IR immediates
//
// Every output is registered. Each register is loaded from the value the
// outputs must take for the *next* state and *next* IR, so the outputs seen
// in a cycle always describe the current state with no combinational path
// from the inputs.
module regfile_ctrl_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  aluop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    localparam int unsigned IR_W  = 16;
    localparam int unsigned REG_W = 3;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_t;

    // Instruction class decode helpers
    function automatic logic is_mov_imm(input logic [IR_W-1:0] ir);
        return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
    endfunction

    function automatic logic is_mov_reg(input logic [IR_W-1:0] ir);
        return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
    endfunction

    function automatic logic is_alu(input logic [IR_W-1:0] ir);
        return ir[15:13] == 3'b101;
    endfunction

    function automatic logic is_mvn(input logic [IR_W-1:0] ir);
        return is_alu(ir) && (ir[12:11] == 2'b11);
    endfunction

    function automatic logic is_cmp(input logic [IR_W-1:0] ir);
        return is_alu(ir) && (ir[12:11] == 2'b01);
    endfunction

    state_t            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;

    logic              w_d;
    logic [REG_W-1:0]  readnum_d, writenum_d;
    logic              write_d, vsel_d;
    logic              loada_d, loadb_d, loadc_d, loads_d;
    logic              asel_d, bsel_d;
    logic [1:0]        aluop_d, shift_d;
    logic [IR_W-1:0]   sximm8_d, sximm5_d;

    // Next state, next IR, and the outputs belonging to that next state
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        w_d        = 1'b0;
        readnum_d  = '0;
        writenum_d = '0;
        write_d    = 1'b0;
        vsel_d     = 1'b0;
        loada_d    = 1'b0;
        loadb_d    = 1'b0;
        loadc_d    = 1'b0;
        loads_d    = 1'b0;
        asel_d     = 1'b0;
        bsel_d     = 1'b0;
        aluop_d    = 2'b00;
        shift_d    = 2'b00;
        sximm8_d   = '0;
        sximm5_d   = '0;

        // load is only honoured while idle; s on the same edge sees the new IR
        if ((state_q == S_WAIT) && load) begin
            ir_d = in;
        end

        case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm(ir_q)) begin
                    state_d = S_WRITE_IMM;
                end else if (is_mov_reg(ir_q) || is_mvn(ir_q)) begin
                    state_d = S_GET_B;
                end else if (is_alu(ir_q)) begin
                    state_d = S_GET_A;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_EXEC;
            S_EXEC:      state_d = is_cmp(ir_q) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            S_WRITE_IMM: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase

        case (state_d)
            S_WAIT: begin
                w_d = 1'b1;
            end
            S_GET_A: begin
                readnum_d = ir_d[10:8];
                loada_d   = 1'b1;
            end
            S_GET_B: begin
                readnum_d = ir_d[2:0];
                loadb_d   = 1'b1;
            end
            S_EXEC: begin
                // MOV Rd,Rm and MVN pass B through, so A is forced to zero
                asel_d = is_mov_reg(ir_d) || is_mvn(ir_d);
                bsel_d = 1'b0;
                if (is_cmp(ir_d)) begin
                    loads_d = 1'b1;
                end else begin
                    loadc_d = 1'b1;
                end
            end
            S_WRITE_REG: begin
                writenum_d = ir_d[7:5];
                write_d    = 1'b1;
                vsel_d     = 1'b0;
            end
            S_WRITE_IMM: begin
                writenum_d = ir_d[10:8];
                write_d    = 1'b1;
                vsel_d     = 1'b1;
            end
            default: begin
                w_d = 1'b0;
            end
        endcase

        // IR-derived fields, independent of state
        if (is_mov_reg(ir_d) || is_alu(ir_d)) begin
            shift_d = ir_d[4:3];
        end
        if (is_alu(ir_d)) begin
            aluop_d = ir_d[12:11];
        end
        sximm8_d = {{8{ir_d[7]}}, ir_d[7:0]};
        sximm5_d = {{11{ir_d[4]}}, ir_d[4:0]};
    end

    // State, IR and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_WAIT;
            ir_q     <= '0;
            w        <= 1'b1;
            readnum  <= '0;
            writenum <= '0;
            write    <= 1'b0;
            vsel     <= 1'b0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            loadc    <= 1'b0;
            loads    <= 1'b0;
            asel     <= 1'b0;
            bsel     <= 1'b0;
            aluop    <= 2'b00;
            shift    <= 2'b00;
            sximm8   <= '0;
            sximm5   <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            w        <= w_d;
            readnum  <= readnum_d;
            writenum <= writenum_d;
            write    <= write_d;
            vsel     <= vsel_d;
            loada    <= loada_d;
            loadb    <= loadb_d;
            loadc    <= loadc_d;
            loads    <= loads_d;
            asel     <= asel_d;
            bsel     <= bsel_d;
            aluop    <= aluop_d;
            shift    <= shift_d;
            sximm8   <= sximm8_d;
            sximm5   <= sximm5_d;
        end
    end

endmodule

// File: tb/tb_regfile_ctrl_fsm.sv
// Testbench for regfile_ctrl_fsm: directed per-cycle vectors queued by the
// driver, compared by an independent monitor after every rising edge.
module tb_regfile_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset, load, s;
    logic [15:0] in;
    logic        w, write, vsel, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  aluop, shift;
    logic [15:0] sximm8, sximm5;

    regfile_ctrl_fsm dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .aluop(aluop), .shift(shift),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        vsel;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  aluop;
        logic [1:0]  shift;
        logic [15:0] sximm8;
        logic [15:0] sximm5;
    } vec_t;

    vec_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;

    // IR-derived part of an expectation, all state-driven controls zero
    function automatic vec_t bs(input logic [1:0] op, input logic [1:0] sh,
                                input logic [15:0] i8, input logic [15:0] i5);
        vec_t v;
        v = '0;
        v.aluop  = op;
        v.shift  = sh;
        v.sximm8 = i8;
        v.sximm5 = i5;
        return v;
    endfunction

    function automatic vec_t mk(input vec_t b, input logic w_e,
                                input logic [2:0] rn, input logic [2:0] wn,
                                input logic wr, input logic vs,
                                input logic la, input logic lb,
                                input logic lc, input logic ls,
                                input logic as);
        vec_t v;
        v = b;
        v.w = w_e; v.readnum = rn; v.writenum = wn; v.write = wr; v.vsel = vs;
        v.loada = la; v.loadb = lb; v.loadc = lc; v.loads = ls; v.asel = as;
        return v;
    endfunction

    function automatic vec_t idle(input vec_t b);
        return mk(b, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t busy(input vec_t b);
        return mk(b, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Drive one cycle of inputs; queue the outputs expected after the next edge
    task automatic step(input logic rst, input logic ld, input logic st,
                        input logic [15:0] din, input vec_t e, input string tag);
        reset = rst; load = ld; s = st; in = din;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // Monitor: compare every queued expectation just after its edge
    initial begin
        vec_t  e, got;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                got = vec_t'({w, readnum, writenum, write, vsel, loada, loadb,
                              loadc, loads, asel, bsel, aluop, shift, sximm8, sximm5});
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s: got=%h expected=%h", t, got, e);
                end
            end
        end
    end

    initial begin
        vec_t b0, bmi, badd, bcmp, bmr, bmvn, band;
        b0   = bs(2'b00, 2'b00, 16'h0000, 16'h0000);
        bmi  = bs(2'b00, 2'b00, 16'hFFF6, 16'hFFF6);   // D1F6
        badd = bs(2'b00, 2'b00, 16'hFFA1, 16'h0001);   // A2A1
        bcmp = bs(2'b01, 2'b00, 16'h0000, 16'h0000);   // A900
        bmr  = bs(2'b00, 2'b10, 16'hFFB3, 16'hFFF3);   // C0B3
        bmvn = bs(2'b11, 2'b00, 16'hFFE2, 16'h0002);   // B8E2
        band = bs(2'b10, 2'b11, 16'h005B, 16'hFFFB);   // B35B

        reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000;
        @(negedge clk);

        step(1, 0, 0, 16'h0000, idle(b0), "reset0");
        step(1, 0, 0, 16'h0000, idle(b0), "reset1");

        // MOV R1,#-10
        step(0, 1, 0, 16'hD1F6, idle(bmi), "movi_load");
        step(0, 0, 1, 16'h0000, busy(bmi), "movi_decode");
        step(0, 0, 0, 16'h0000, mk(bmi, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0), "movi_write_imm");
        step(0, 0, 0, 16'h0000, idle(bmi), "movi_wait");

        // ADD R5,R2,R1 with load+s together, s held high for back-to-back
        step(0, 1, 1, 16'hA2A1, busy(badd), "add_decode");
        step(0, 0, 1, 16'h0000, mk(badd, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0), "add_get_a");
        step(0, 0, 1, 16'h0000, mk(badd, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0), "add_get_b");
        step(0, 0, 1, 16'h0000, mk(badd, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "add_exec");
        step(0, 0, 1, 16'h0000, mk(badd, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0), "add_write_reg");
        step(0, 0, 1, 16'h0000, idle(badd), "add_wait_one");
        step(0, 0, 1, 16'h0000, busy(badd), "add2_decode");
        // load while busy is ignored; IR still ADD
        step(0, 1, 0, 16'hFFFF, mk(badd, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0), "add2_get_a_ldff");
        step(0, 1, 0, 16'hFFFF, mk(badd, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0), "add2_get_b_ldff");
        step(0, 0, 1, 16'h0000, mk(badd, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "add2_exec");
        step(0, 0, 1, 16'h0000, mk(badd, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0), "add2_write_reg");
        step(0, 0, 0, 16'h0000, idle(badd), "add2_wait");
        step(0, 0, 0, 16'h0000, idle(badd), "add2_s_not_remembered");

        // CMP R1,R0
        step(0, 1, 0, 16'hA900, idle(bcmp), "cmp_load");
        step(0, 0, 1, 16'h0000, busy(bcmp), "cmp_decode");
        step(0, 0, 0, 16'h0000, mk(bcmp, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), "cmp_get_a");
        step(0, 0, 0, 16'h0000, mk(bcmp, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "cmp_get_b");
        step(0, 0, 0, 16'h0000, mk(bcmp, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "cmp_exec");
        step(0, 0, 0, 16'h0000, idle(bcmp), "cmp_wait");

        // MOV R5,R3,LSR
        step(0, 1, 0, 16'hC0B3, idle(bmr), "movr_load");
        step(0, 0, 1, 16'h0000, busy(bmr), "movr_decode");
        step(0, 0, 0, 16'h0000, mk(bmr, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0), "movr_get_b");
        step(0, 0, 0, 16'h0000, mk(bmr, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "movr_exec");
        step(0, 0, 0, 16'h0000, mk(bmr, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0), "movr_write_reg");
        step(0, 0, 0, 16'h0000, idle(bmr), "movr_wait");

        // MVN R7,R2
        step(0, 1, 0, 16'hB8E2, idle(bmvn), "mvn_load");
        step(0, 0, 1, 16'h0000, busy(bmvn), "mvn_decode");
        step(0, 0, 0, 16'h0000, mk(bmvn, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0), "mvn_get_b");
        step(0, 0, 0, 16'h0000, mk(bmvn, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "mvn_exec");
        step(0, 0, 0, 16'h0000, mk(bmvn, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0), "mvn_write_reg");
        step(0, 0, 0, 16'h0000, idle(bmvn), "mvn_wait");

        // AND R2,R3,R3,ASR
        step(0, 1, 0, 16'hB35B, idle(band), "and_load");
        step(0, 0, 1, 16'h0000, busy(band), "and_decode");
        step(0, 0, 0, 16'h0000, mk(band, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0), "and_get_a");
        step(0, 0, 0, 16'h0000, mk(band, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0), "and_get_b");
        step(0, 0, 0, 16'h0000, mk(band, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "and_exec");
        step(0, 0, 0, 16'h0000, mk(band, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0), "and_write_reg");
        step(0, 0, 0, 16'h0000, idle(band), "and_wait");

        // Reset during GET_B of an ADD
        step(0, 1, 0, 16'hA2A1, idle(badd), "rst_add_load");
        step(0, 0, 1, 16'h0000, busy(badd), "rst_add_decode");
        step(0, 0, 0, 16'h0000, mk(badd, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0), "rst_add_get_a");
        step(0, 0, 0, 16'h0000, mk(badd, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0), "rst_add_get_b");
        step(1, 0, 0, 16'h0000, idle(b0), "rst_mid_instr");
        step(0, 0, 0, 16'h0000, idle(b0), "rst_after_no_write");

        // Illegal opcode
        step(0, 1, 0, 16'hE000, idle(b0), "ill_load");
        step(0, 0, 1, 16'h0000, busy(b0), "ill_decode");
        step(0, 0, 0, 16'h0000, idle(b0), "ill_wait");

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
